// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: holds the PC, assembles each 32-bit instruction
// from four little-endian byte reads over the byte-wide memory port, and
// presents pc/instruction to the IF/ID register with a busy flag.
//
// Handshakes:
//   Memory port  - mem_req_o is a request level. A byte is accepted on any
//                  edge where mem_req_o=1 and mem_ready_i=1; mem_data_i then
//                  belongs to mem_addr_o. mem_ready_i is ignored while
//                  mem_req_o=0.
//   IF/ID output - if_busy_o=0 means if_pc/if_inst hold a valid instruction.
//                  It is consumed on the first edge with stall_i=0. A jump
//                  drops it regardless of stall_i.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        jump_i,
    input  logic [31:0] jump_addr_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ready_i,
    input  logic [7:0]  mem_data_i,
    output logic        if_busy_o,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [1:0]  byte_cnt;
    logic [23:0] asm_buf;

    // The FSM state is exposed for checkers; it is a register, so this is
    // a registered output as well.
    assign state_dbg = state;

    // Fetch FSM: reset, jump redirect, byte assembly and hand-off to IF/ID.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            byte_cnt   <= 2'd0;
            asm_buf    <= 24'd0;
            mem_req_o  <= 1'b0;
            mem_addr_o <= 32'd0;
            if_busy_o  <= 1'b1;
            if_pc      <= 32'd0;
            if_inst    <= 32'd0;
        end else if (jump_i) begin
            // Redirect wins over stall and memory; any partial or presented
            // instruction is abandoned and the target is word-aligned.
            state      <= FETCH;
            pc         <= {jump_addr_i[31:2], 2'b00};
            byte_cnt   <= 2'd0;
            asm_buf    <= 24'd0;
            mem_req_o  <= 1'b1;
            mem_addr_o <= {jump_addr_i[31:2], 2'b00};
            if_busy_o  <= 1'b1;
            if_pc      <= 32'd0;
            if_inst    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    state      <= FETCH;
                    mem_req_o  <= 1'b1;
                    mem_addr_o <= pc;
                end
                FETCH: begin
                    if (mem_ready_i) begin
                        if (byte_cnt == 2'd3) begin
                            if_inst   <= {mem_data_i, asm_buf};
                            if_pc     <= pc;
                            if_busy_o <= 1'b0;
                            mem_req_o <= 1'b0;
                            byte_cnt  <= 2'd0;
                            state     <= VALID;
                        end else begin
                            case (byte_cnt)
                                2'd0:    asm_buf[7:0]   <= mem_data_i;
                                2'd1:    asm_buf[15:8]  <= mem_data_i;
                                default: asm_buf[23:16] <= mem_data_i;
                            endcase
                            byte_cnt   <= byte_cnt + 2'd1;
                            // Byte address wraps modulo 2^32 like the PC.
                            mem_addr_o <= pc + {30'd0, byte_cnt} + 32'd1;
                        end
                    end
                end
                VALID: begin
                    if (!stall_i) begin
                        pc         <= pc + 32'd4;
                        if_busy_o  <= 1'b1;
                        if_inst    <= 32'd0;
                        if_pc      <= 32'd0;
                        mem_req_o  <= 1'b1;
                        mem_addr_o <= pc + 32'd4;
                        state      <= FETCH;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a combinational byte memory answers
// every address, and each step checks outputs 1 ns after the rising edge.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        jump_i;
    logic [31:0] jump_addr_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ready_i;
    logic [7:0]  mem_data_i;
    logic        if_busy_o;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic [1:0]  state_dbg;

    int tests_run;
    int tests_failed;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_VALID = 2'd2;

    if_fetch_unit #(.RESET_PC(32'h0)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_i    (stall_i),
        .jump_i     (jump_i),
        .jump_addr_i(jump_addr_i),
        .mem_req_o  (mem_req_o),
        .mem_addr_o (mem_addr_o),
        .mem_ready_i(mem_ready_i),
        .mem_data_i (mem_data_i),
        .if_busy_o  (if_busy_o),
        .if_pc      (if_pc),
        .if_inst    (if_inst),
        .state_dbg  (state_dbg)
    );

    // Clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: 13 05 10 00 at 0..3, otherwise low address byte ^ 5A.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'd0:   return 8'h13;
            32'd1:   return 8'h05;
            32'd2:   return 8'h10;
            32'd3:   return 8'h00;
            default: return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    always_comb mem_data_i = mem_byte(mem_addr_o);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"},   {31'd0, mem_req_o}, 32'd0);
        chk({tag, "_addr"},  mem_addr_o, 32'd0);
        chk({tag, "_busy"},  {31'd0, if_busy_o}, 32'd1);
        chk({tag, "_pc"},    if_pc, 32'd0);
        chk({tag, "_inst"},  if_inst, 32'd0);
        chk({tag, "_state"}, {30'd0, state_dbg}, {30'd0, S_IDLE});
    endtask

    task automatic chk_valid(input string tag, input logic [31:0] pc, input logic [31:0] inst);
        chk({tag, "_busy"}, {31'd0, if_busy_o}, 32'd0);
        chk({tag, "_pc"},   if_pc, pc);
        chk({tag, "_inst"}, if_inst, inst);
        chk({tag, "_req"},  {31'd0, mem_req_o}, 32'd0);
    endtask

    // Bounded wait for a presented instruction; a timeout is a failed check.
    task automatic wait_valid(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (if_busy_o && n < max_cycles) begin
            tick();
            n++;
        end
        chk({tag, "_timeout"}, {31'd0, if_busy_o}, 32'd0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        stall_i      = 1'b0;
        jump_i       = 1'b0;
        jump_addr_i  = 32'd0;
        mem_ready_i  = 1'b0;
        tick();
        tick();
        chk_reset("rst");

        // Reset release, ready tied high: addresses 0..3, then present.
        rst         = 1'b0;
        mem_ready_i = 1'b1;
        tick();
        chk("t1_state", {30'd0, state_dbg}, {30'd0, S_FETCH});
        chk("t1_req",   {31'd0, mem_req_o}, 32'd1);
        chk("t1_a0",    mem_addr_o, 32'd0);
        tick(); chk("t1_a1", mem_addr_o, 32'd1);
        tick(); chk("t1_a2", mem_addr_o, 32'd2);
        tick(); chk("t1_a3", mem_addr_o, 32'd3);
        chk("t1_busy3", {31'd0, if_busy_o}, 32'd1);
        tick();
        chk_valid("t1_v", 32'd0, 32'h00100513);
        tick();
        chk("t1_cons_busy", {31'd0, if_busy_o}, 32'd1);
        chk("t1_cons_req",  {31'd0, mem_req_o}, 32'd1);
        chk("t1_cons_addr", mem_addr_o, 32'd4);
        chk("t1_cons_inst", if_inst, 32'd0);
        // Next instruction appears in the 5th cycle after its first FETCH cycle.
        tick(); tick(); tick();
        chk("t1_busy_c4", {31'd0, if_busy_o}, 32'd1);
        chk("t1_a7",      mem_addr_o, 32'd7);
        stall_i = 1'b1;
        tick();
        chk_valid("t1_v2", 32'd4, 32'h5D5C5F5E);

        // Stall held 4 cycles in VALID.
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_valid($sformatf("st_hold%0d", i), 32'd4, 32'h5D5C5F5E);
        end
        stall_i = 1'b0;
        tick();
        chk("st_rel_busy", {31'd0, if_busy_o}, 32'd1);
        chk("st_rel_addr", mem_addr_o, 32'd8);
        chk("st_rel_req",  {31'd0, mem_req_o}, 32'd1);

        // Ready for one cycle after each 2-cycle gap.
        for (int k = 0; k < 4; k++) begin
            mem_ready_i = 1'b0;
            tick();
            tick();
            chk($sformatf("gap%0d_addr", k), mem_addr_o, 32'd8 + k);
            chk($sformatf("gap%0d_busy", k), {31'd0, if_busy_o}, 32'd1);
            mem_ready_i = 1'b1;
            tick();
            if (k < 3) chk($sformatf("gap%0d_adv", k), mem_addr_o, 32'd9 + k);
        end
        chk_valid("gap_v", 32'd8, 32'h51505352);
        tick();
        chk("gap_cons_addr", mem_addr_o, 32'hC);

        // Jump after two bytes fetched, with ready high on the jump edge.
        tick(); chk("j1_a_d", mem_addr_o, 32'hD);
        tick(); chk("j1_a_e", mem_addr_o, 32'hE);
        jump_i      = 1'b1;
        jump_addr_i = 32'h103;
        tick();
        jump_i = 1'b0;
        chk("j1_addr", mem_addr_o, 32'h100);
        chk("j1_busy", {31'd0, if_busy_o}, 32'd1);
        chk("j1_req",  {31'd0, mem_req_o}, 32'd1);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk($sformatf("j1_a%0d", i), mem_addr_o, 32'h100 + i);
            chk($sformatf("j1_busy%0d", i), {31'd0, if_busy_o}, 32'd1);
        end
        stall_i = 1'b1;
        tick();
        chk_valid("j1_v", 32'h100, 32'h59585B5A);

        // Jump during stalled VALID drops the instruction; then wrap at 2^32.
        tick();
        chk_valid("j2_hold", 32'h100, 32'h59585B5A);
        jump_i      = 1'b1;
        jump_addr_i = 32'hFFFFFFFC;
        tick();
        jump_i = 1'b0;
        chk("j2_busy", {31'd0, if_busy_o}, 32'd1);
        chk("j2_pc",   if_pc, 32'd0);
        chk("j2_inst", if_inst, 32'd0);
        chk("j2_addr", mem_addr_o, 32'hFFFFFFFC);
        tick(); chk("j2_a_fd", mem_addr_o, 32'hFFFFFFFD);
        tick(); chk("j2_a_fe", mem_addr_o, 32'hFFFFFFFE);
        tick(); chk("j2_a_ff", mem_addr_o, 32'hFFFFFFFF);
        tick();
        chk_valid("j2_v", 32'hFFFFFFFC, 32'hA5A4A7A6);
        tick();
        chk_valid("j2_v_hold", 32'hFFFFFFFC, 32'hA5A4A7A6);
        stall_i = 1'b0;
        tick();
        chk("wrap_addr", mem_addr_o, 32'd0);
        chk("wrap_busy", {31'd0, if_busy_o}, 32'd1);

        // Reset mid-fetch at byte_cnt=2, then refetch from RESET_PC.
        tick(); chk("r_a1", mem_addr_o, 32'd1);
        tick(); chk("r_a2", mem_addr_o, 32'd2);
        rst = 1'b1;
        tick();
        chk_reset("rst_mid");
        rst = 1'b0;
        tick();
        chk("r_refetch_addr",  mem_addr_o, 32'd0);
        chk("r_refetch_state", {30'd0, state_dbg}, {30'd0, S_FETCH});
        stall_i = 1'b1;
        wait_valid("r_refetch", 20);
        chk_valid("r_v", 32'd0, 32'h00100513);

        // Back-to-back jumps: the last one wins.
        jump_i      = 1'b1;
        jump_addr_i = 32'h200;
        tick();
        chk("bb_a1", mem_addr_o, 32'h200);
        jump_addr_i = 32'h9;
        tick();
        jump_i = 1'b0;
        chk("bb_a2", mem_addr_o, 32'h8);
        wait_valid("bb", 20);
        chk_valid("bb_v", 32'h8, 32'h51505352);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
